// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit_pkg
// Purpose  : Shared definitions for the load/store path: opcode values,
//            LSU state encoding, memory access width encoding and the
//            opcode decode helper (also used by memory_controller).
// Revision : 1.0  initial release
// ============================================================================
package load_store_unit_pkg;

  // Opcode field values for the memory instructions
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ0  = 3'd1,
    ST_WAIT0 = 3'd2,
    ST_REQ1  = 3'd3,
    ST_WAIT1 = 3'd4,
    ST_FIN   = 3'd5
  } lsu_state_e;

  typedef enum logic [1:0] {
    MEM_W = 2'b00,
    MEM_H = 2'b01,
    MEM_B = 2'b10
  } mem_width_e;

  typedef struct packed {
    logic       is_mem;
    logic       we;
    mem_width_e width;
    logic       sign;
  } mem_op_t;

  function automatic mem_op_t decode_mem_op(input logic [5:0] op);
    mem_op_t d;
    d.is_mem = 1'b1;
    d.we     = 1'b0;
    d.width  = MEM_W;
    d.sign   = 1'b0;
    case (op)
      OP_LB:  begin d.width = MEM_B; d.sign = 1'b1; end
      OP_LH:  begin d.width = MEM_H; d.sign = 1'b1; end
      OP_LW:  d.width = MEM_W;
      OP_LBU: d.width = MEM_B;
      OP_LHU: d.width = MEM_H;
      OP_SB:  begin d.width = MEM_B; d.we = 1'b1; end
      OP_SH:  begin d.width = MEM_H; d.we = 1'b1; end
      OP_SW:  begin d.width = MEM_W; d.we = 1'b1; end
      default: d.is_mem = 1'b0;
    endcase
    return d;
  endfunction

  // Natural alignment check: halfwords on even, words on multiple-of-4
  function automatic logic is_misaligned(input mem_width_e w, input logic [1:0] a);
    return ((w == MEM_H) && a[0]) || ((w == MEM_W) && (a != 2'b00));
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit_if
// Purpose  : Word-addressed data-memory bus with req/gnt request phase and
//            rvalid response phase.
// Ports    : master = LSU side (drives req/we/adrs/be/wdata),
//            slave  = memory side (drives gnt/rvalid/rdata).
// Revision : 1.0  initial release
// ============================================================================
interface load_store_unit_if #(
  parameter int N_RAM_ADRS_W = 16
);
  logic                    mem_req;
  logic                    mem_we;
  logic [N_RAM_ADRS_W-1:0] mem_adrs;
  logic [3:0]              mem_be;
  logic [31:0]             mem_wdata;
  logic                    mem_gnt;
  logic                    mem_rvalid;
  logic [31:0]             mem_rdata;

  modport master (
    output mem_req, mem_we, mem_adrs, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_adrs, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Purpose  : Combinational lane steering for the LSU. Builds byte enables
//            and lane-aligned write data for access 0/1, flags accesses
//            that straddle a word boundary, and merges/extends load data.
// Ports    : width/sign/a   access width, signedness, byte offset
//            idx            0 = first word, 1 = following word
//            st_data        right-justified store data
//            r0/r1          read words of access 0/1
//            be/wdata       lane enables and data for access idx
//            split          access needs a second word
//            result         aligned, extended load value
// Revision : 1.0  initial release
// ============================================================================
module lsu_align
  import load_store_unit_pkg::*;
(
  input  mem_width_e  width,
  input  logic        sign,
  input  logic [1:0]  a,
  input  logic        idx,
  input  logic [31:0] st_data,
  input  logic [31:0] r0,
  input  logic [31:0] r1,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        split,
  output logic [31:0] result
);

  logic [7:0]  base;
  logic [7:0]  mask;
  logic [5:0]  sh_lo;
  logic [5:0]  sh_hi;
  logic [31:0] raw;

  always_comb begin
    case (width)
      MEM_B:   base = 8'h01;
      MEM_H:   base = 8'h03;
      default: base = 8'h0F;
    endcase
  end

  // Upper nibble of the shifted mask holds the lanes of the next word
  assign mask  = base << a;
  assign split = |mask[7:4];

  // sh_hi reaches 32 when a == 0, which shifts everything out; that case
  // only matters for idx == 1 / split, which cannot happen with a == 0.
  assign sh_lo = {1'b0, a, 3'b000};
  assign sh_hi = 6'd32 - sh_lo;

  assign be    = idx ? mask[7:4] : mask[3:0];
  assign wdata = idx ? (st_data >> sh_hi) : (st_data << sh_lo);

  assign raw   = (r0 >> sh_lo) | (split ? (r1 << sh_hi) : 32'h0);

  always_comb begin
    case (width)
      MEM_B:   result = {{24{sign & raw[7]}}, raw[7:0]};
      MEM_H:   result = {{16{sign & raw[15]}}, raw[15:0]};
      default: result = raw;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Purpose  : Data-memory initiator between execute stage and memory.
//            Decodes load/store ops, issues word requests with byte enables
//            over req/gnt/rvalid, splits word-crossing accesses, merges and
//            extends load data, and times out silent responses.
// Macro    : LSU_MISALIGN_EN - when defined, misaligned accesses are split
//            into two word requests; otherwise they are rejected with a
//            one-cycle exc_misalign pulse and never reach the bus.
// Ports    : clk_cpu, reset (async, active-high)
//            ex_valid/ex_ready/ex_op/ex_adrs/ex_data  execute-stage request
//            mem (load_store_unit_if.master)          memory bus
//            wb_valid/wb_data                         load writeback
//            done/err/exc_misalign                    completion pulses
// Revision : 1.0  initial release
// ============================================================================
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int MAX_WAIT     = 16,
  parameter int N_RAM_ADRS_W = 16
) (
  input  logic                     clk_cpu,
  input  logic                     reset,
  input  logic                     ex_valid,
  output logic                     ex_ready,
  input  logic [5:0]               ex_op,
  input  logic [31:0]              ex_adrs,
  input  logic [31:0]              ex_data,
  load_store_unit_if.master        mem,
  output logic                     wb_valid,
  output logic [31:0]              wb_data,
  output logic                     done,
  output logic                     err,
  output logic                     exc_misalign
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  lsu_state_e              state_q, state_d;
  logic                    we_q, we_d;
  mem_width_e              width_q, width_d;
  logic                    sign_q, sign_d;
  logic [1:0]              a_q, a_d;
  logic [N_RAM_ADRS_W-1:0] word_q, word_d;
  logic [31:0]             data_q, data_d;
  logic [31:0]             r0_q, r0_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [31:0]             wb_data_q, wb_data_d;
  logic                    wb_valid_q, wb_valid_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    exc_misalign_q, exc_misalign_d;

  mem_op_t     dec;
  logic        req;
  logic        idx;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        split;
  logic [31:0] result;
  logic [31:0] r0_in;
  logic [31:0] r1_in;
  logic        unused_adrs_hi;

  assign dec            = decode_mem_op(ex_op);
  assign unused_adrs_hi = ^ex_adrs[31:N_RAM_ADRS_W+2];

  // Merge inputs see the word arriving this cycle so the extended result
  // can be registered on the same edge that enters FIN.
  assign r0_in = ((state_q == ST_WAIT0) && mem.mem_rvalid) ? mem.mem_rdata : r0_q;

`ifdef LSU_MISALIGN_EN
  logic [31:0] r1_q, r1_d;
  assign r1_in = ((state_q == ST_WAIT1) && mem.mem_rvalid) ? mem.mem_rdata : r1_q;
`else
  logic unused_split;
  assign r1_in        = 32'h0;
  assign unused_split = split;
`endif

  assign idx = (state_q == ST_REQ1);
  assign req = (state_q == ST_REQ0) || (state_q == ST_REQ1);

  lsu_align u_align (
    .width   (width_q),
    .sign    (sign_q),
    .a       (a_q),
    .idx     (idx),
    .st_data (data_q),
    .r0      (r0_in),
    .r1      (r1_in),
    .be      (be),
    .wdata   (wdata),
    .split   (split),
    .result  (result)
  );

  // Bus outputs are zero outside request states
  assign mem.mem_req   = req;
  assign mem.mem_we    = req & we_q;
  assign mem.mem_adrs  = !req ? '0 : (idx ? word_q + N_RAM_ADRS_W'(1) : word_q);
  assign mem.mem_be    = req ? be : 4'b0000;
  assign mem.mem_wdata = req ? wdata : 32'h0;

  assign ex_ready     = (state_q == ST_IDLE);
  assign wb_valid     = wb_valid_q;
  assign wb_data      = wb_data_q;
  assign done         = done_q;
  assign err          = err_q;
  assign exc_misalign = exc_misalign_q;

  always_comb begin
    state_d        = state_q;
    we_d           = we_q;
    width_d        = width_q;
    sign_d         = sign_q;
    a_d            = a_q;
    word_d         = word_q;
    data_d         = data_q;
    r0_d           = r0_in;
    cnt_d          = '0;
    wb_data_d      = wb_data_q;
    err_d          = 1'b0;
    exc_misalign_d = 1'b0;
`ifdef LSU_MISALIGN_EN
    r1_d           = r1_in;
`endif

    case (state_q)
      ST_IDLE: begin
        if (ex_valid && ex_ready && dec.is_mem) begin
          we_d    = dec.we;
          width_d = dec.width;
          sign_d  = dec.sign;
          a_d     = ex_adrs[1:0];
          word_d  = ex_adrs[N_RAM_ADRS_W+1:2];
          data_d  = ex_data;
`ifdef LSU_MISALIGN_EN
          state_d = ST_REQ0;
`else
          if (is_misaligned(dec.width, ex_adrs[1:0])) begin
            exc_misalign_d = 1'b1;
          end else begin
            state_d = ST_REQ0;
          end
`endif
        end
      end

      ST_REQ0: begin
        if (mem.mem_gnt) begin
          if (!we_q) begin
            state_d = ST_WAIT0;
`ifdef LSU_MISALIGN_EN
          end else if (split) begin
            state_d = ST_REQ1;
`endif
          end else begin
            state_d = ST_FIN;
          end
        end
      end

      ST_WAIT0: begin
        if (mem.mem_rvalid) begin
`ifdef LSU_MISALIGN_EN
          state_d = split ? ST_REQ1 : ST_FIN;
`else
          state_d = ST_FIN;
`endif
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

`ifdef LSU_MISALIGN_EN
      ST_REQ1: begin
        if (mem.mem_gnt) begin
          state_d = we_q ? ST_FIN : ST_WAIT1;
        end
      end

      ST_WAIT1: begin
        if (mem.mem_rvalid) begin
          state_d = ST_FIN;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif

      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Completion flags are registered on entry so they are high during FIN
    done_d     = (state_d == ST_FIN);
    wb_valid_d = (state_d == ST_FIN) && !we_q;
    if (wb_valid_d) begin
      wb_data_d = result;
    end
  end

  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      we_q           <= 1'b0;
      width_q        <= MEM_W;
      sign_q         <= 1'b0;
      a_q            <= 2'b00;
      word_q         <= '0;
      data_q         <= 32'h0;
      r0_q           <= 32'h0;
      cnt_q          <= '0;
      wb_data_q      <= 32'h0;
      wb_valid_q     <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      exc_misalign_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      we_q           <= we_d;
      width_q        <= width_d;
      sign_q         <= sign_d;
      a_q            <= a_d;
      word_q         <= word_d;
      data_q         <= data_d;
      r0_q           <= r0_d;
      cnt_q          <= cnt_d;
      wb_data_q      <= wb_data_d;
      wb_valid_q     <= wb_valid_d;
      done_q         <= done_d;
      err_q          <= err_d;
      exc_misalign_q <= exc_misalign_d;
    end
  end

`ifdef LSU_MISALIGN_EN
  always_ff @(posedge clk_cpu or posedge reset) begin
    if (reset) begin
      r1_q <= 32'h0;
    end else begin
      r1_q <= r1_d;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Purpose  : Directed, self-checking bench for load_store_unit. The memory
//            side is driven cycle by cycle from the test tasks; outputs are
//            sampled on the falling clock edge.
// Macro    : LSU_MISALIGN_EN selects the split-access or the reject tests.
// Revision : 1.0  initial release
// ============================================================================
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk_cpu = 1'b0;
  logic        reset   = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [5:0]  ex_op   = 6'h00;
  logic [31:0] ex_adrs = 32'h0;
  logic [31:0] ex_data = 32'h0;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic        done;
  logic        err;
  logic        exc_misalign;

  int n_checks = 0;
  int n_pass   = 0;

  load_store_unit_if #(.N_RAM_ADRS_W(16)) mem_if ();

  load_store_unit #(.MAX_WAIT(16), .N_RAM_ADRS_W(16)) dut (
    .clk_cpu      (clk_cpu),
    .reset        (reset),
    .ex_valid     (ex_valid),
    .ex_ready     (ex_ready),
    .ex_op        (ex_op),
    .ex_adrs      (ex_adrs),
    .ex_data      (ex_data),
    .mem          (mem_if),
    .wb_valid     (wb_valid),
    .wb_data      (wb_data),
    .done         (done),
    .err          (err),
    .exc_misalign (exc_misalign)
  );

  always #5 clk_cpu = ~clk_cpu;

  task automatic tick();
    @(posedge clk_cpu);
    @(negedge clk_cpu);
  endtask

  // Present one op for a single accept cycle; returns in the cycle after accept
  task automatic issue(input logic [5:0] op, input logic [31:0] adrs, input logic [31:0] data);
    ex_valid = 1'b1; ex_op = op; ex_adrs = adrs; ex_data = data;
    tick();
    ex_valid = 1'b0;
  endtask

  // Zero-wait single-word load; returns in the FIN cycle
  task automatic load_op(input logic [5:0] op, input logic [31:0] adrs, input logic [31:0] rword);
    issue(op, adrs, 32'h0);
    mem_if.mem_gnt = 1'b1; tick(); mem_if.mem_gnt = 1'b0;
    mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = rword; tick();
    mem_if.mem_rvalid = 1'b0; mem_if.mem_rdata = 32'h0;
  endtask

  task automatic test_reset();
    @(negedge clk_cpu);
    n_checks++; if (mem_if.mem_req !== 1'b0 || mem_if.mem_we !== 1'b0) $display("FAIL rst_req_we: got %b%b want 00", mem_if.mem_req, mem_if.mem_we); else n_pass++;
    n_checks++; if (mem_if.mem_be !== 4'h0 || mem_if.mem_wdata !== 32'h0) $display("FAIL rst_be_wdata: got %h %h want 0 0", mem_if.mem_be, mem_if.mem_wdata); else n_pass++;
    n_checks++; if ({wb_valid, done, err, exc_misalign} !== 4'b0000) $display("FAIL rst_pulses: got %b want 0000", {wb_valid, done, err, exc_misalign}); else n_pass++;
    n_checks++; if (wb_data !== 32'h0) $display("FAIL rst_wb_data: got %h want 00000000", wb_data); else n_pass++;
    n_checks++; if (ex_ready !== 1'b1) $display("FAIL rst_ex_ready: got %b want 1", ex_ready); else n_pass++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_lw();
    issue(OP_LW, 32'h10, 32'h0);
    n_checks++; if (mem_if.mem_req !== 1'b1 || mem_if.mem_we !== 1'b0) $display("FAIL lw_req: got req=%b we=%b want 1 0", mem_if.mem_req, mem_if.mem_we); else n_pass++;
    n_checks++; if (mem_if.mem_adrs !== 16'h0004 || mem_if.mem_be !== 4'b1111) $display("FAIL lw_adrs_be: got %h %b want 0004 1111", mem_if.mem_adrs, mem_if.mem_be); else n_pass++;
    n_checks++; if (ex_ready !== 1'b0) $display("FAIL lw_stall: got ex_ready=%b want 0", ex_ready); else n_pass++;
    mem_if.mem_gnt = 1'b1; tick(); mem_if.mem_gnt = 1'b0;
    n_checks++; if (mem_if.mem_req !== 1'b0 || wb_valid !== 1'b0) $display("FAIL lw_wait: got req=%b wb_valid=%b want 0 0", mem_if.mem_req, wb_valid); else n_pass++;
    mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 32'h8899AABB; tick();
    mem_if.mem_rvalid = 1'b0; mem_if.mem_rdata = 32'h0;
    n_checks++; if (wb_valid !== 1'b1 || done !== 1'b1) $display("FAIL lw_fin: got wb_valid=%b done=%b want 1 1", wb_valid, done); else n_pass++;
    n_checks++; if (wb_data !== 32'h8899AABB) $display("FAIL lw_data: got %h want 8899aabb", wb_data); else n_pass++;
    tick();
    n_checks++; if (wb_valid !== 1'b0 || done !== 1'b0 || ex_ready !== 1'b1) $display("FAIL lw_after: got wbv=%b done=%b rdy=%b want 0 0 1", wb_valid, done, ex_ready); else n_pass++;
    n_checks++; if (wb_data !== 32'h8899AABB) $display("FAIL lw_hold: got %h want 8899aabb", wb_data); else n_pass++;
  endtask

  task automatic test_extend();
    issue(OP_LB, 32'h13, 32'h0);
    n_checks++; if (mem_if.mem_be !== 4'b1000 || mem_if.mem_adrs !== 16'h0004) $display("FAIL lb_be: got %b %h want 1000 0004", mem_if.mem_be, mem_if.mem_adrs); else n_pass++;
    mem_if.mem_gnt = 1'b1; tick(); mem_if.mem_gnt = 1'b0;
    mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 32'h80112233; tick(); mem_if.mem_rvalid = 1'b0;
    n_checks++; if (wb_data !== 32'hFFFFFF80 || wb_valid !== 1'b1) $display("FAIL lb_sext: got %h v=%b want ffffff80 1", wb_data, wb_valid); else n_pass++;
    tick();
    load_op(OP_LBU, 32'h13, 32'h80112233);
    n_checks++; if (wb_data !== 32'h00000080) $display("FAIL lbu_zext: got %h want 00000080", wb_data); else n_pass++;
    tick();
    load_op(OP_LBU, 32'h11, 32'h80112233);
    n_checks++; if (wb_data !== 32'h00000022) $display("FAIL lbu_lane1: got %h want 00000022", wb_data); else n_pass++;
    tick();
    load_op(OP_LH, 32'h02, 32'h80011234);
    n_checks++; if (wb_data !== 32'hFFFF8001) $display("FAIL lh_sext: got %h want ffff8001", wb_data); else n_pass++;
    tick();
    load_op(OP_LHU, 32'h02, 32'h80011234);
    n_checks++; if (wb_data !== 32'h00008001) $display("FAIL lhu_zext: got %h want 00008001", wb_data); else n_pass++;
    tick();
    load_op(OP_LH, 32'h00, 32'h12347FFE);
    n_checks++; if (wb_data !== 32'h00007FFE) $display("FAIL lh_pos: got %h want 00007ffe", wb_data); else n_pass++;
    tick();
  endtask

  task automatic test_store();
    issue(OP_SH, 32'h06, 32'h0000BEEF);
    n_checks++; if (mem_if.mem_req !== 1'b1 || mem_if.mem_we !== 1'b1) $display("FAIL sh_req: got req=%b we=%b want 1 1", mem_if.mem_req, mem_if.mem_we); else n_pass++;
    n_checks++; if (mem_if.mem_adrs !== 16'h0001 || mem_if.mem_be !== 4'b1100 || mem_if.mem_wdata !== 32'hBEEF0000) $display("FAIL sh_bus: got %h %b %h want 0001 1100 beef0000", mem_if.mem_adrs, mem_if.mem_be, mem_if.mem_wdata); else n_pass++;
    tick(); tick();
    n_checks++; if (mem_if.mem_req !== 1'b1 || mem_if.mem_adrs !== 16'h0001 || mem_if.mem_wdata !== 32'hBEEF0000) $display("FAIL sh_hold: got req=%b %h %h want 1 0001 beef0000", mem_if.mem_req, mem_if.mem_adrs, mem_if.mem_wdata); else n_pass++;
    mem_if.mem_gnt = 1'b1; tick(); mem_if.mem_gnt = 1'b0;
    n_checks++; if (done !== 1'b1 || wb_valid !== 1'b0) $display("FAIL sh_done: got done=%b wbv=%b want 1 0", done, wb_valid); else n_pass++;
    n_checks++; if (wb_data !== 32'h00007FFE) $display("FAIL sh_wb_hold: got %h want 00007ffe", wb_data); else n_pass++;
    tick();
    issue(OP_SW, 32'h20, 32'h12345678);
    n_checks++; if (mem_if.mem_adrs !== 16'h0008 || mem_if.mem_be !== 4'b1111 || mem_if.mem_wdata !== 32'h12345678) $display("FAIL sw_bus: got %h %b %h want 0008 1111 12345678", mem_if.mem_adrs, mem_if.mem_be, mem_if.mem_wdata); else n_pass++;
    mem_if.mem_gnt = 1'b1; tick(); mem_if.mem_gnt = 1'b0;
    n_checks++; if (done !== 1'b1 || mem_if.mem_req !== 1'b0) $display("FAIL sw_latency: got done=%b req=%b want 1 0", done, mem_if.mem_req); else n_pass++;
    tick();
    issue(OP_SB, 32'h05, 32'hFFFFFFA5);
    n_checks++; if (mem_if.mem_be !== 4'b0010 || mem_if.mem_wdata[15:8] !== 8'hA5) $display("FAIL sb_bus: got %b %h want 0010 lane1=a5", mem_if.mem_be, mem_if.mem_wdata); else n_pass++;
    mem_if.mem_gnt = 1'b1; tick(); mem_if.mem_gnt = 1'b0;
    tick();
  endtask

  task automatic test_gnt_rvalid_same_cycle();
    issue(OP_LW, 32'h04, 32'h0);
    mem_if.mem_gnt = 1'b1; mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 32'hDEADBEEF; tick();
    mem_if.mem_gnt = 1'b0; mem_if.mem_rvalid = 1'b0;
    n_checks++; if (wb_valid !== 1'b0 || done !== 1'b0) $display("FAIL early_rvalid: got wbv=%b done=%b want 0 0", wb_valid, done); else n_pass++;
    mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 32'hCAFEF00D; tick(); mem_if.mem_rvalid = 1'b0;
    n_checks++; if (wb_valid !== 1'b1 || wb_data !== 32'hCAFEF00D) $display("FAIL late_rvalid: got v=%b %h want 1 cafef00d", wb_valid, wb_data); else n_pass++;
    tick();
  endtask

  task automatic test_nonmem();
    issue(6'h00, 32'h10, 32'h0);
    n_checks++; if (ex_ready !== 1'b1 || mem_if.mem_req !== 1'b0 || exc_misalign !== 1'b0) $display("FAIL nonmem: got rdy=%b req=%b exc=%b want 1 0 0", ex_ready, mem_if.mem_req, exc_misalign); else n_pass++;
    tick();
  endtask

  task automatic test_timeout();
    logic bad;
    bad = 1'b0;
    issue(OP_LW, 32'h08, 32'h0);
    mem_if.mem_gnt = 1'b1; tick(); mem_if.mem_gnt = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (err !== 1'b0 || wb_valid !== 1'b0 || ex_ready !== 1'b0) bad = 1'b1;
      tick();
    end
    n_checks++; if (bad !== 1'b0) $display("FAIL tmo_early: got early err/ready=%b want 0", bad); else n_pass++;
    tick();
    n_checks++; if (err !== 1'b1 || wb_valid !== 1'b0 || done !== 1'b0) $display("FAIL tmo_err: got err=%b wbv=%b done=%b want 1 0 0", err, wb_valid, done); else n_pass++;
    n_checks++; if (ex_ready !== 1'b1) $display("FAIL tmo_ready: got %b want 1", ex_ready); else n_pass++;
    tick();
    n_checks++; if (err !== 1'b0) $display("FAIL tmo_pulse: got %b want 0", err); else n_pass++;
  endtask

  task automatic test_reset_midflight();
    issue(OP_LW, 32'h0C, 32'h0);
    #2 reset = 1'b1;
    #1;
    n_checks++; if (mem_if.mem_req !== 1'b0 || mem_if.mem_be !== 4'h0) $display("FAIL rst_req0: got req=%b be=%b want 0 0000", mem_if.mem_req, mem_if.mem_be); else n_pass++;
    @(negedge clk_cpu); reset = 1'b0; tick();
    issue(OP_LW, 32'h0C, 32'h0);
    mem_if.mem_gnt = 1'b1; tick(); mem_if.mem_gnt = 1'b0;
    #2 reset = 1'b1;
    #1;
    n_checks++; if (ex_ready !== 1'b1 || {mem_if.mem_req, wb_valid, done} !== 3'b000) $display("FAIL rst_wait0: got rdy=%b req/wbv/done=%b want 1 000", ex_ready, {mem_if.mem_req, wb_valid, done}); else n_pass++;
    n_checks++; if (wb_data !== 32'h0) $display("FAIL rst_wb_clr: got %h want 00000000", wb_data); else n_pass++;
    @(negedge clk_cpu); reset = 1'b0; tick();
    load_op(OP_LW, 32'h0C, 32'h13572468);
    n_checks++; if (wb_valid !== 1'b1 || done !== 1'b1 || wb_data !== 32'h13572468) $display("FAIL rst_recover: got v=%b d=%b %h want 1 1 13572468", wb_valid, done, wb_data); else n_pass++;
    tick();
  endtask

`ifdef LSU_MISALIGN_EN
  task automatic test_split();
    issue(OP_LW, 32'h0B, 32'h0);
    n_checks++; if (mem_if.mem_adrs !== 16'h0002 || mem_if.mem_be !== 4'b1000) $display("FAIL spl_r0: got %h %b want 0002 1000", mem_if.mem_adrs, mem_if.mem_be); else n_pass++;
    mem_if.mem_gnt = 1'b1; tick(); mem_if.mem_gnt = 1'b0;
    mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 32'h44332211; tick(); mem_if.mem_rvalid = 1'b0;
    n_checks++; if (mem_if.mem_req !== 1'b1 || mem_if.mem_adrs !== 16'h0003 || mem_if.mem_be !== 4'b0111) $display("FAIL spl_r1: got req=%b %h %b want 1 0003 0111", mem_if.mem_req, mem_if.mem_adrs, mem_if.mem_be); else n_pass++;
    mem_if.mem_gnt = 1'b1; tick(); mem_if.mem_gnt = 1'b0;
    mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 32'h88776655; tick(); mem_if.mem_rvalid = 1'b0;
    n_checks++; if (wb_valid !== 1'b1 || done !== 1'b1 || wb_data !== 32'h77665544) $display("FAIL spl_load: got v=%b d=%b %h want 1 1 77665544", wb_valid, done, wb_data); else n_pass++;
    tick();
    issue(OP_SH, 32'h0003FFFF, 32'h00001234);
    n_checks++; if (mem_if.mem_adrs !== 16'hFFFF || mem_if.mem_be !== 4'b1000 || mem_if.mem_wdata !== 32'h34000000) $display("FAIL spl_st0: got %h %b %h want ffff 1000 34000000", mem_if.mem_adrs, mem_if.mem_be, mem_if.mem_wdata); else n_pass++;
    mem_if.mem_gnt = 1'b1; tick(); mem_if.mem_gnt = 1'b0;
    n_checks++; if (mem_if.mem_adrs !== 16'h0000 || mem_if.mem_be !== 4'b0001 || mem_if.mem_wdata !== 32'h00000012) $display("FAIL spl_wrap: got %h %b %h want 0000 0001 00000012", mem_if.mem_adrs, mem_if.mem_be, mem_if.mem_wdata); else n_pass++;
    mem_if.mem_gnt = 1'b1; tick(); mem_if.mem_gnt = 1'b0;
    n_checks++; if (done !== 1'b1 || wb_valid !== 1'b0) $display("FAIL spl_st_done: got d=%b v=%b want 1 0", done, wb_valid); else n_pass++;
    tick();
  endtask
`else
  task automatic test_misalign();
    issue(OP_LH, 32'h01, 32'h0);
    n_checks++; if (exc_misalign !== 1'b1 || mem_if.mem_req !== 1'b0 || ex_ready !== 1'b1) $display("FAIL mis_lh: got exc=%b req=%b rdy=%b want 1 0 1", exc_misalign, mem_if.mem_req, ex_ready); else n_pass++;
    tick();
    n_checks++; if (exc_misalign !== 1'b0 || mem_if.mem_req !== 1'b0 || done !== 1'b0) $display("FAIL mis_pulse: got exc=%b req=%b done=%b want 0 0 0", exc_misalign, mem_if.mem_req, done); else n_pass++;
    issue(OP_LW, 32'h0B, 32'h0);
    n_checks++; if (exc_misalign !== 1'b1 || mem_if.mem_req !== 1'b0) $display("FAIL mis_lw: got exc=%b req=%b want 1 0", exc_misalign, mem_if.mem_req); else n_pass++;
    tick();
    issue(OP_SH, 32'h07, 32'h0);
    n_checks++; if (exc_misalign !== 1'b1 || mem_if.mem_req !== 1'b0) $display("FAIL mis_sh: got exc=%b req=%b want 1 0", exc_misalign, mem_if.mem_req); else n_pass++;
    tick();
    n_checks++; if (done !== 1'b0 || mem_if.mem_req !== 1'b0) $display("FAIL mis_nodone: got done=%b req=%b want 0 0", done, mem_if.mem_req); else n_pass++;
  endtask
`endif

  initial begin
    mem_if.mem_gnt    = 1'b0;
    mem_if.mem_rvalid = 1'b0;
    mem_if.mem_rdata  = 32'h0;
    test_reset();
    test_lw();
    test_extend();
    test_store();
    test_gnt_rvalid_same_cycle();
    test_nonmem();
    test_timeout();
    test_reset_midflight();
`ifdef LSU_MISALIGN_EN
    test_split();
`else
    test_misalign();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test want finish before 200000");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- CPU-side initiator for data-memory accesses; sits between the execute stage and the RAM/memory controller.
- Decodes load/store opcodes and issues word-addressed requests with byte enables over a req/gnt/rvalid handshake.
- Splits accesses that cross a word boundary into two requests, then merges, aligns and sign/zero-extends load data for writeback.
- Includes a response timeout.

Parameters:
- MAX_WAIT, 16: cycles allowed in a wait state without mem_rvalid before bus error.
- N_RAM_ADRS_W, 16: width of the word address driven on mem_adrs.

Ports:
- clk_cpu  in  1  CPU clock.
- reset  in  1  asynchronous, active-high reset.
- ex_valid  in  1  execute stage presents an operation.
- ex_ready  out  1  LSU can accept; high only in IDLE.
- ex_op  in  6  instruction opcode field (`OP_lb/lh/lw/lbu/lhu/sb/sh/sw).
- ex_adrs  in  32  byte address.
- ex_data  in  32  store data, right-justified.
- mem_req  out  1  request valid.
- mem_we  out  1  1 = write.
- mem_adrs  out  N_RAM_ADRS_W  word address.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-aligned write data.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read word.
- wb_valid  out  1  one-cycle pulse: load result valid.
- wb_data  out  32  extended load result.
- done  out  1  one-cycle pulse: operation finished (load or store).
- err  out  1  one-cycle pulse: timeout.
- exc_misalign  out  1  one-cycle pulse: misaligned access rejected (feature off only).

Behaviour:
- Reset (async, any state): state=IDLE. mem_req, mem_we, mem_be, mem_wdata, wb_valid, wb_data, done, err, exc_misalign all 0. Wait counter = 0. An in-flight request is abandoned.
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, FIN.
- IDLE:
  - ex_valid && ex_ready && load/store op: capture op, adrs, data; go to REQ0.
  - Non-memory op: ignored; stay in IDLE.
- Width/extension: B and H loads sign-extend for lb/lh and zero-extend for lbu/lhu. W needs no extension.
- Let a = adrs[1:0]. Base mask m = 4'b0001 (B), 4'b0011 (H), 4'b1111 (W), held in 8 bits.
  - Shifted mask M = m << a.
  - Access 0 uses word adrs>>2, be = M[3:0], wdata = data << 8a.
  - Split iff M[7:4] != 0. Access 1 uses word (adrs>>2)+1, be = M[7:4], wdata = data >> 8(4-a).
  - Word address wraps modulo 2^N_RAM_ADRS_W.
- REQ0/REQ1:
  - mem_req=1; address, be, wdata and we are held stable until mem_gnt.
  - On gnt, a store moves to REQ1 (if split) or FIN.
  - On gnt, a load moves to WAIT0/WAIT1.
- WAIT0/WAIT1:
  - mem_req=0. On mem_rvalid, latch rdata.
  - rvalid in the same cycle as gnt is not accepted: rvalid is only sampled in WAIT states.
  - WAIT0 moves to REQ1 if split, else FIN. WAIT1 moves to FIN.
  - Counter increments each cycle without rvalid and clears on state entry.
  - Counter == MAX_WAIT-1 without rvalid: err pulse next cycle, go to IDLE, no wb_valid and no done.
- Merge: raw = (r0 >> 8a) | (split ? r1 << 8(4-a) : 0), then extend per width.
- FIN (one cycle):
  - done=1.
  - Loads also assert wb_valid=1 and wb_data=result; wb_data holds until the next load completes.
  - Go to IDLE.
- Latency, zero-wait memory (gnt in REQ cycle, rvalid next cycle):
  - Aligned load: 4 cycles from accept to wb_valid.
  - Split load: 6 cycles.
  - Aligned store: 3 cycles to done.
- ex_ready is low from REQ0 until returning to IDLE; the execute stage stalls.

Optional Feature:
- Macro LSU_MISALIGN_EN.
- Defined: split access as above.
- Undefined:
  - Any H with a[0]=1 or W with a!=0 is not issued.
  - Accept moves directly to IDLE with exc_misalign pulsed one cycle after accept. No done; mem_req never asserted.
  - REQ1/WAIT1 logic is compiled out.
  - Byte ops and aligned ops behave identically in both builds.

Decomposition:
- Add to the shared defines/package:
  - LSU state enum.
  - MEM_WIDTH encodings (W=00, H=01, B=10).
  - Opcode-to-{we,width,sign} decode function, reused by memory_controller.
- Sub-module lsu_align: combinational. Covers be/wdata generation per access index, load merge and extension. Testable standalone.

Test Plan:
- lw adrs=0x10, mem word4=0x8899AABB, zero-wait → mem_be=1111, wb_data=0x8899AABB 4 cycles after accept, done pulse.
- lb adrs=0x13 from word 0x80112233 → wb_data=0xFFFFFF80; lbu → 0x00000080.
- sh adrs=0x06, ex_data=0x0000BEEF → one request, word 1, be=1100, wdata=0xBEEF0000, done 3 cycles after accept.
- Feature on: lw adrs=0x0B, word2=0x44332211, word3=0x88776655 → requests to word 2 be=1000 then word 3 be=0111, wb_data=0x77665544. Feature off: exc_misalign pulse, mem_req never high.
- Load with mem_rvalid withheld and MAX_WAIT=16 → err pulses 16 cycles after WAIT0 entry, no wb_valid, ex_ready high next cycle.
- Reset asserted in WAIT0 → mem_req, wb_valid, done = 0 immediately. After release, a fresh lw completes normally.
